mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit, directly downstream of the decode control unit.
- Consumes the decoded MemWrite[3:0], MemToReg and LdStCtrl[2:0] values, plus the ALU effective address and the rt store data.
- Aligns stores onto big-endian byte lanes and runs a request/ack handshake with data memory.
- Stalls the pipeline while an access is outstanding and returns sign- or zero-extended load data to writeback.

---
 rtl/mem_stage_lsu_if.sv | 19 +
 rtl/mem_stage_lsu.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Request/ack bus between the MEM-stage load/store unit (master) and data memory (slave).
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: big-endian lane alignment, request/ack handshake, load extension.
// LSU_MISALIGN_TRAP_EN: drop misaligned accesses with a pulse; otherwise force the low address bits to 0.
module mem_stage_lsu #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic                  mem_to_reg,
  input  logic [3:0]            mem_write,
  input  logic [2:0]            ld_st_ctrl,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  mem_stage_lsu_if.master       dmem,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  misaligned,
  output logic                  bus_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e            state, state_next;
  size_e             size;
  logic              mem_op, misal;
  logic              accept, drop, done, abort;
  logic [1:0]        lane, lane_q;
  logic [3:0]        we_c;
  logic [31:0]       wdata_c, ext_c;
  logic [2:0]        ctrl_q;
  logic              is_load_q;
  logic [TMO_W-1:0]  cnt;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // Access size from the load/store control code
  always_comb begin
    size = SZ_B;
    case (ld_st_ctrl)
      3'b001, 3'b100, 3'b110: size = SZ_H;
      3'b010, 3'b111:         size = SZ_W;
      default:                size = SZ_B;
    endcase
  end

  assign mem_op = op_valid & (mem_to_reg | (mem_write != 4'b0000));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = ((size == SZ_H) & addr[0]) | ((size == SZ_W) & (addr[1:0] != 2'b00));
  assign lane  = addr[1:0];
`else
  assign misal = 1'b0;
  always_comb begin
    lane = addr[1:0];
    if (size == SZ_H) begin
      lane[0] = 1'b0;
    end else if (size == SZ_W) begin
      lane = 2'b00;
    end
  end
`endif

  // Lane 0 is the most significant byte; narrow store data is replicated across lanes
  always_comb begin
    we_c    = 4'b1111;
    wdata_c = store_data;
    case (size)
      SZ_B: begin
        we_c    = 4'b1000 >> lane;
        wdata_c = {4{store_data[7:0]}};
      end
      SZ_H: begin
        we_c    = lane[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    if (mem_write == 4'b0000) begin
      we_c = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, handshake events and the combinational stall
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drop       = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (misal) begin
            drop = 1'b1;
          end else begin
            accept     = 1'b1;
            stall      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (cnt == TMO_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Load lane extraction from the returned word
  always_comb begin
    case (lane_q)
      2'd0:    byte_v = dmem.dmem_rdata[31:24];
      2'd1:    byte_v = dmem.dmem_rdata[23:16];
      2'd2:    byte_v = dmem.dmem_rdata[15:8];
      default: byte_v = dmem.dmem_rdata[7:0];
    endcase
    half_v = lane_q[1] ? dmem.dmem_rdata[15:0] : dmem.dmem_rdata[31:16];
    case (ctrl_q)
      3'b000:  ext_c = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext_c = {{16{half_v[15]}}, half_v};
      3'b011:  ext_c = {24'h000000, byte_v};
      3'b100:  ext_c = {16'h0000, half_v};
      default: ext_c = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 4'b0000;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wdata <= 32'h0;
      load_data       <= 32'h0;
      load_valid      <= 1'b0;
      misaligned      <= 1'b0;
      bus_err         <= 1'b0;
      ctrl_q          <= 3'b000;
      lane_q          <= 2'b00;
      is_load_q       <= 1'b0;
      cnt             <= '0;
    end else begin
      load_valid <= 1'b0;
      misaligned <= drop;
      bus_err    <= abort;
      if (accept) begin
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= we_c;
        dmem.dmem_addr  <= {addr[31:2], 2'b00};
        dmem.dmem_wdata <= wdata_c;
        ctrl_q          <= ld_st_ctrl;
        lane_q          <= lane;
        is_load_q       <= mem_to_reg;
        cnt             <= '0;
      end else if (done || abort) begin
        dmem.dmem_req <= 1'b0;
        dmem.dmem_we  <= 4'b0000;
        if (done && is_load_q) begin
          load_data  <= ext_c;
          load_valid <= 1'b1;
        end
      end else if (state == BUSY) begin
        cnt <= cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized ops against a reference model.
module tb_mem_stage_lsu;
  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic [3:0]  mem_write = 4'h0;
  logic [2:0]  ld_st_ctrl = 3'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        stall, load_valid, misaligned, bus_err;
  logic [31:0] load_data;
  int checks = 0;
  int errors = 0;

  mem_stage_lsu_if dmem_bus();

  mem_stage_lsu #(.ACK_TIMEOUT(T), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .ld_st_ctrl(ld_st_ctrl), .addr(addr), .store_data(store_data),
    .dmem(dmem_bus), .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req_seen;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          stall_n;
    int          cycles;
    int          lv_n;
    logic [31:0] ld;
    int          mis_n;
    int          be_n;
    bit          unstable;
    bit          tmo;
  } obs_t;

  function automatic int op_size(input logic [2:0] c);
    case (c)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic obs_t blank();
    obs_t o;
    o.req_seen = 0; o.daddr = 0; o.we = 0; o.wdata = 0; o.stall_n = 0; o.cycles = 0;
    o.lv_n = 0; o.ld = 0; o.mis_n = 0; o.be_n = 0; o.unstable = 0; o.tmo = 0;
    return o;
  endfunction

  // Reference: what the access should look like, from byte offsets and arithmetic
  function automatic obs_t model(input bit ld, input logic [2:0] c, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd, input int dly,
                                 input logic [31:0] prev_ld);
    obs_t e;
    int sz, off;
    logic [31:0] m, v;
    e = blank();
    e.ld = prev_ld;
    sz = op_size(c);
    off = int'(a % 4);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((off % sz) != 0) begin
      e.mis_n = 1;
      e.cycles = 1;
      return e;
    end
`endif
    off = off - (off % sz);
    e.req_seen = 1;
    e.daddr = a - (a % 4);
    if (!ld) for (int k = off; k < off + sz; k++) e.we[3-k] = 1'b1;
    m = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 32'h1;
    v = sd & m;
    e.wdata = (sz == 1) ? v * 32'h0101_0101 : (sz == 2) ? v * 32'h0001_0001 : sd;
    if (dly < int'(T)) begin
      e.stall_n = 1 + dly;
      e.cycles = dly + 2;
      if (ld) begin
        e.lv_n = 1;
        v = (rd >> (8 * (4 - off - sz))) & m;
        if ((c == 3'd0 || c == 3'd1) && v[8*sz-1]) v = v | ~m;
        e.ld = v;
      end
    end else begin
      e.stall_n = int'(T);
      e.cycles = int'(T) + 1;
      e.be_n = 1;
    end
    return e;
  endfunction

  // Presents one op and plays the memory; ack after dly BUSY cycles without it. Starts/ends at posedge+1.
  task automatic run_op(input bit ld, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int dly, output obs_t o);
    int busy_n, sz;
    bit fin;
    o = blank();
    sz = op_size(c);
    op_valid = 1'b1;
    mem_to_reg = ld;
    mem_write = ld ? 4'b0000 : (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
    ld_st_ctrl = c;
    addr = a;
    store_data = sd;
    busy_n = 0;
    fin = 0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      dmem_bus.dmem_ack = 1'b0;
      dmem_bus.dmem_rdata = $urandom;
      if (dmem_bus.dmem_req) begin
        if (busy_n == 0) begin
          o.req_seen = 1;
          o.daddr = dmem_bus.dmem_addr;
          o.we = dmem_bus.dmem_we;
          o.wdata = dmem_bus.dmem_wdata;
        end else if (o.daddr !== dmem_bus.dmem_addr || o.we !== dmem_bus.dmem_we ||
                     o.wdata !== dmem_bus.dmem_wdata) begin
          o.unstable = 1;
        end
        if (busy_n == dly) begin
          dmem_bus.dmem_ack = 1'b1;
          dmem_bus.dmem_rdata = rd;
        end
        busy_n++;
      end
      #1;
      if (stall) o.stall_n++;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      o.cycles = cyc + 1;
      if (load_valid) o.lv_n++;
      if (misaligned) o.mis_n++;
      if (bus_err) o.be_n++;
      if (!dmem_bus.dmem_req) fin = 1;
    end
    dmem_bus.dmem_ack = 1'b0;
    if (!fin) o.tmo = 1;
    o.ld = load_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_bus.dmem_req); end
    checks++; if (dmem_bus.dmem_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h expected 0", dmem_bus.dmem_we); end
    checks++; if (dmem_bus.dmem_addr !== 32'h0 || dmem_bus.dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", dmem_bus.dmem_addr, dmem_bus.dmem_wdata); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data: got %h expected 0", load_data); end
    checks++; if ({load_valid, misaligned, bus_err, stall} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {load_valid, misaligned, bus_err, stall}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    obs_t o;
    run_op(1'b0, 3'd7, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, o);
    checks++; if (o.daddr !== 32'h104 || o.we !== 4'b1111 || o.wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_bus: got %h/%b/%h expected 00000104/1111/deadbeef", o.daddr, o.we, o.wdata); end
    checks++; if (o.stall_n != 1 || o.cycles != 2) begin errors++; $display("FAIL sw_timing: got stall %0d cycles %0d expected 1/2", o.stall_n, o.cycles); end
    run_op(1'b0, 3'd5, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1, o);
    checks++; if (o.daddr !== 32'h200 || o.we !== 4'b0001 || o.wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_bus: got %h/%b/%h expected 00000200/0001/a5a5a5a5", o.daddr, o.we, o.wdata); end
    run_op(1'b0, 3'd6, 32'h0000_0302, 32'h1234_5678, 32'h0, 0, o);
    checks++; if (o.we !== 4'b0011 || o.wdata !== 32'h5678_5678 || o.lv_n != 0) begin errors++; $display("FAIL sh_bus: got %b/%h lv %0d expected 0011/56785678 lv 0", o.we, o.wdata, o.lv_n); end
  endtask

  task automatic test_load();
    obs_t o;
    logic [31:0] held;
    run_op(1'b1, 3'd0, 32'h0000_0101, 32'h0, 32'h12F4_5678, 3, o);
    checks++; if (o.stall_n != 4 || o.lv_n != 1 || o.ld !== 32'hFFFF_FFF4) begin errors++; $display("FAIL lb: got stall %0d lv %0d data %h expected 4/1/fffffff4", o.stall_n, o.lv_n, o.ld); end
    checks++; if (o.we !== 4'b0000 || o.unstable) begin errors++; $display("FAIL lb_bus: got we %b unstable %0d expected 0000/0", o.we, o.unstable); end
    held = load_data;
    @(posedge clk);
    #1;
    checks++; if (load_valid !== 1'b0 || load_data !== held) begin errors++; $display("FAIL lv_pulse_hold: got %b/%h expected 0/%h", load_valid, load_data, held); end
    run_op(1'b1, 3'd3, 32'h0000_0101, 32'h0, 32'h12F4_5678, 0, o);
    checks++; if (o.ld !== 32'h0000_00F4) begin errors++; $display("FAIL lbu: got %h expected 000000f4", o.ld); end
    run_op(1'b1, 3'd1, 32'h0000_0102, 32'h0, 32'h1234_ABCD, 1, o);
    checks++; if (o.ld !== 32'hFFFF_ABCD) begin errors++; $display("FAIL lh: got %h expected ffffabcd", o.ld); end
    run_op(1'b1, 3'd4, 32'h0000_0102, 32'h0, 32'h1234_ABCD, 2, o);
    checks++; if (o.ld !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu: got %h expected 0000abcd", o.ld); end
    run_op(1'b1, 3'd2, 32'h0000_0100, 32'h0, 32'h8765_4321, 0, o);
    checks++; if (o.ld !== 32'h8765_4321) begin errors++; $display("FAIL lw: got %h expected 87654321", o.ld); end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_op(1'b1, 3'd2, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (o.req_seen || o.mis_n != 1 || o.stall_n != 0 || o.lv_n != 0) begin errors++; $display("FAIL misalign_trap: got req %0d mis %0d stall %0d lv %0d expected 0/1/0/0", o.req_seen, o.mis_n, o.stall_n, o.lv_n); end
`else
    checks++; if (!o.req_seen || o.daddr !== 32'h100 || o.mis_n != 0 || o.ld !== 32'hCAFE_F00D) begin errors++; $display("FAIL misalign_force: got req %0d addr %h mis %0d data %h expected 1/00000100/0/cafef00d", o.req_seen, o.daddr, o.mis_n, o.ld); end
`endif
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [31:0] held;
    held = load_data;
    run_op(1'b1, 3'd2, 32'h0000_0400, 32'h0, 32'h1111_2222, 4, o);
    checks++; if (o.be_n != 1 || o.lv_n != 0 || o.cycles != 5 || o.stall_n != 4) begin errors++; $display("FAIL timeout: got be %0d lv %0d cycles %0d stall %0d expected 1/0/5/4", o.be_n, o.lv_n, o.cycles, o.stall_n); end
    checks++; if (o.ld !== held) begin errors++; $display("FAIL timeout_hold: got %h expected %h", o.ld, held); end
    run_op(1'b1, 3'd2, 32'h0000_0400, 32'h0, 32'h3333_4444, 3, o);
    checks++; if (o.be_n != 0 || o.lv_n != 1 || o.ld !== 32'h3333_4444) begin errors++; $display("FAIL ack_wins: got be %0d lv %0d data %h expected 0/1/33334444", o.be_n, o.lv_n, o.ld); end
  endtask

  task automatic test_reset_busy();
    int late;
    op_valid = 1'b1; mem_to_reg = 1'b1; mem_write = 4'h0; ld_st_ctrl = 3'd2; addr = 32'h300;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_enter: got req %b expected 1", dmem_bus.dmem_req); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({dmem_bus.dmem_req, stall, load_valid, bus_err} !== 4'b0000) begin errors++; $display("FAIL rst_busy: got req/stall/lv/be %b expected 0000", {dmem_bus.dmem_req, stall, load_valid, bus_err}); end
    rst_n = 1'b1;
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'h5555_AAAA;
    late = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      dmem_bus.dmem_ack = 1'b0;
      if (load_valid || bus_err || dmem_bus.dmem_req) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL rst_abandon: got %0d stray events expected 0", late); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    time t0;
    t0 = $time;
    run_op(1'b0, 3'd7, 32'h0000_0500, 32'h0BAD_F00D, 32'h0, 0, o1);
    run_op(1'b1, 3'd2, 32'h0000_0504, 32'h0, 32'h7777_8888, 0, o2);
    checks++; if (($time - t0) != 40 || o2.ld !== 32'h7777_8888) begin errors++; $display("FAIL back_to_back: got %0t ns data %h expected 40 ns 77778888", $time - t0, o2.ld); end
  endtask

  task automatic test_random();
    obs_t o, e;
    bit ld;
    logic [2:0] c;
    logic [31:0] a, sd, rd, prev;
    int dly;
    for (int n = 0; n < 60; n++) begin
      c = 3'($urandom_range(0, 7));
      ld = (c < 3'd5);
      a = $urandom;
      sd = $urandom;
      rd = $urandom;
      dly = $urandom_range(0, 5);
      prev = load_data;
      e = model(ld, c, a, sd, rd, dly, prev);
      run_op(ld, c, a, sd, rd, dly, o);
      checks++; if (o.tmo || o.unstable || o.req_seen != e.req_seen) begin errors++; $display("FAIL rnd_req[%0d]: got req %0d unstable %0d hang %0d expected req %0d", n, o.req_seen, o.unstable, o.tmo, e.req_seen); end
      if (e.req_seen) begin
        checks++; if (o.daddr !== e.daddr || o.we !== e.we) begin errors++; $display("FAIL rnd_addr_we[%0d]: got %h/%b expected %h/%b", n, o.daddr, o.we, e.daddr, e.we); end
        if (!ld) begin
          checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, o.wdata, e.wdata); end
        end
      end
      checks++; if (o.stall_n != e.stall_n || o.cycles != e.cycles) begin errors++; $display("FAIL rnd_timing[%0d]: got stall %0d cycles %0d expected %0d/%0d", n, o.stall_n, o.cycles, e.stall_n, e.cycles); end
      checks++; if (o.lv_n != e.lv_n || o.ld !== e.ld) begin errors++; $display("FAIL rnd_load[%0d]: got lv %0d data %h expected %0d/%h", n, o.lv_n, o.ld, e.lv_n, e.ld); end
      checks++; if (o.mis_n != e.mis_n || o.be_n != e.be_n) begin errors++; $display("FAIL rnd_pulses[%0d]: got mis %0d be %0d expected %0d/%0d", n, o.mis_n, o.be_n, e.mis_n, e.be_n); end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
